// File: rtl/instr_dispatch_unit.sv
// Buffered dispatch front-end between the custom-instruction port and the sprite register bank / sprite memory.
// Optional feature macro: IDU_DROP_COUNT_EN adds a saturating drop_count output for ignored and illegal instructions.
module instr_dispatch_unit #(
    parameter int FIFO_DEPTH = 8,
    parameter int OPCODE_W   = 4,
    parameter int ADDR_W     = 14,
    parameter int REG_W      = 5,
    parameter int MEM_DATA_W = 9,
    parameter int OP_WBR     = 0,
    parameter int OP_WSM     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic [31:0]                     dataA,
    input  logic [31:0]                     dataB,
    input  logic                            printting_screen,
    output logic                            done_instruction,
    output logic                            reg_wr,
    output logic [REG_W-1:0]                reg_num,
    output logic [31:0]                     reg_data,
    output logic                            mem_wr,
    output logic [ADDR_W-1:0]               mem_address,
    output logic [MEM_DATA_W-1:0]           mem_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            busy,
    output logic                            error_sticky
`ifdef IDU_DROP_COUNT_EN
    ,
    output logic [7:0]                      drop_count
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = OPCODE_W + ADDR_W + 32;
    localparam logic [OPCODE_W-1:0] OP_WBR_C = OPCODE_W'(OP_WBR);
    localparam logic [OPCODE_W-1:0] OP_WSM_C = OPCODE_W'(OP_WSM);
    localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ENTRY_W-1:0]    skid_data_q, skid_data_d;
    logic                  done_q, done_d;
    logic                  reg_wr_q, reg_wr_d;
    logic [REG_W-1:0]      reg_num_q, reg_num_d;
    logic [31:0]           reg_data_q, reg_data_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [MEM_DATA_W-1:0] mem_data_q, mem_data_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
`ifdef IDU_DROP_COUNT_EN
    logic [7:0]            drop_count_q, drop_count_d;
    logic [8:0]            drop_sum_s;
`endif

    logic                  full_s;
    logic                  empty_s;
    logic                  push_skid_s;
    logic                  push_new_s;
    logic                  load_skid_s;
    logic                  violation_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  illegal_s;
    logic                  is_wbr_s;
    logic                  is_wsm_s;
    logic [ENTRY_W-1:0]    new_entry_s;
    logic [ENTRY_W-1:0]    push_entry_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [OPCODE_W-1:0]   head_op_s;
    logic [ADDR_W-1:0]     head_addr_s;
    logic [31:0]           head_data_s;
    logic                  unused_dataa_s;

    // Upper dataA bits above the address field carry no meaning for this block.
    assign unused_dataa_s = ^dataA;

    // Accept, skid, pop/decode and next-state logic.
    always_comb begin
        new_entry_s  = {dataA[OPCODE_W-1:0], dataA[OPCODE_W +: ADDR_W], dataB};
        full_s       = (count_q == FULL_LVL);
        empty_s      = (count_q == {LVL_W{1'b0}});

        // Skid drains before any new host word; a strobe while skid is occupied is a protocol violation.
        push_skid_s  = skid_valid_q && !full_s;
        push_new_s   = clk_en && !skid_valid_q && !full_s;
        load_skid_s  = clk_en && !skid_valid_q && full_s;
        violation_s  = clk_en && skid_valid_q;
        push_s       = push_skid_s || push_new_s;

        if (push_skid_s) begin
            push_entry_s = skid_data_q;
        end else begin
            push_entry_s = new_entry_s;
        end

        head_s       = fifo_mem_q[rd_ptr_q];
        head_op_s    = head_s[ENTRY_W-1 -: OPCODE_W];
        head_addr_s  = head_s[32 +: ADDR_W];
        head_data_s  = head_s[31:0];
        is_wbr_s     = (head_op_s == OP_WBR_C);
        is_wsm_s     = (head_op_s == OP_WSM_C);

        pop_s        = (state_q == ST_IDLE) && !empty_s && !printting_screen;
        illegal_s    = pop_s && !is_wbr_s && !is_wsm_s;

        if (load_skid_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_entry_s;
        end else if (push_skid_s) begin
            skid_valid_d = 1'b0;
            skid_data_d  = skid_data_q;
        end else begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE:  state_d = pop_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Strobes are registered at the pop edge so they are visible exactly while the FSM sits in ISSUE.
        reg_wr_d = pop_s && is_wbr_s;
        mem_wr_d = pop_s && is_wsm_s;

        if (reg_wr_d) begin
            reg_num_d  = head_addr_s[REG_W-1:0];
            reg_data_d = head_data_s;
        end else begin
            reg_num_d  = reg_num_q;
            reg_data_d = reg_data_q;
        end

        if (mem_wr_d) begin
            mem_address_d = head_addr_s;
            mem_data_d    = head_data_s[MEM_DATA_W-1:0];
        end else begin
            mem_address_d = mem_address_q;
            mem_data_d    = mem_data_q;
        end

        done_d  = push_s;
        error_d = error_q || violation_s || illegal_s;
        busy_d  = (count_d != {LVL_W{1'b0}}) || skid_valid_d || (state_d != ST_IDLE);

`ifdef IDU_DROP_COUNT_EN
        drop_sum_s = {1'b0, drop_count_q} + {8'd0, violation_s} + {8'd0, illegal_s};
        if (drop_sum_s[8]) begin
            drop_count_d = 8'hFF;
        end else begin
            drop_count_d = drop_sum_s[7:0];
        end
`endif
    end

    // FIFO storage; entries need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= push_entry_s;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {LVL_W{1'b0}};
            skid_valid_q  <= 1'b0;
            skid_data_q   <= {ENTRY_W{1'b0}};
            done_q        <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_num_q     <= {REG_W{1'b0}};
            reg_data_q    <= 32'd0;
            mem_wr_q      <= 1'b0;
            mem_address_q <= {ADDR_W{1'b0}};
            mem_data_q    <= {MEM_DATA_W{1'b0}};
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef IDU_DROP_COUNT_EN
            drop_count_q  <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            done_q        <= done_d;
            reg_wr_q      <= reg_wr_d;
            reg_num_q     <= reg_num_d;
            reg_data_q    <= reg_data_d;
            mem_wr_q      <= mem_wr_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
`ifdef IDU_DROP_COUNT_EN
            drop_count_q  <= drop_count_d;
`endif
        end
    end

    assign done_instruction = done_q;
    assign reg_wr           = reg_wr_q;
    assign reg_num          = reg_num_q;
    assign reg_data         = reg_data_q;
    assign mem_wr           = mem_wr_q;
    assign mem_address      = mem_address_q;
    assign mem_data         = mem_data_q;
    assign fifo_level       = count_q;
    assign busy             = busy_q;
    assign error_sticky     = error_q;
`ifdef IDU_DROP_COUNT_EN
    assign drop_count       = drop_count_q;
`endif

endmodule

// File: tb/tb_instr_dispatch_unit.sv
// Directed self-checking bench for instr_dispatch_unit (default parameters).
module tb_instr_dispatch_unit;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        printting_screen;
    logic        done_instruction;
    logic        reg_wr;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        mem_wr;
    logic [13:0] mem_address;
    logic [8:0]  mem_data;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        error_sticky;
`ifdef IDU_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    instr_dispatch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .dataA            (dataA),
        .dataB            (dataB),
        .printting_screen (printting_screen),
        .done_instruction (done_instruction),
        .reg_wr           (reg_wr),
        .reg_num          (reg_num),
        .reg_data         (reg_data),
        .mem_wr           (mem_wr),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .fifo_level       (fifo_level),
        .busy             (busy),
        .error_sticky     (error_sticky)
`ifdef IDU_DROP_COUNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int writes;
        int dones;
        int next_addr;
        int strobes;

        reset = 1'b1; clk_en = 1'b0; dataA = 32'd0; dataB = 32'd0; printting_screen = 1'b0;
        step(); step(); step();
        check("rst_done", {31'd0, done_instruction}, 32'd0);
        check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, error_sticky}, 32'd0);
        check("rst_reg_num", {27'd0, reg_num}, 32'd0);
        reset = 1'b0;
        step();

        // Single WBR: done in cycle 1, strobe in cycle 2
        clk_en = 1'b1; dataA = 32'h50; dataB = 32'd694310912;
        step();
        clk_en = 1'b0;
        check("wbr_done", {31'd0, done_instruction}, 32'd1);
        check("wbr_early_wr", {31'd0, reg_wr}, 32'd0);
        step();
        check("wbr_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("wbr_reg_num", {27'd0, reg_num}, 32'd5);
        check("wbr_reg_data", reg_data, 32'd694310912);
        check("wbr_done_once", {31'd0, done_instruction}, 32'd0);
        step();
        check("wbr_strobe_1cyc", {31'd0, reg_wr}, 32'd0);
        check("wbr_hold_num", {27'd0, reg_num}, 32'd5);
        check("wbr_idle_busy", {31'd0, busy}, 32'd0);

        // Single WSM
        clk_en = 1'b1; dataA = 32'h3fff1; dataB = 32'd12;
        step();
        clk_en = 1'b0;
        check("wsm_done", {31'd0, done_instruction}, 32'd1);
        step();
        check("wsm_mem_wr", {31'd0, mem_wr}, 32'd1);
        check("wsm_addr", {18'd0, mem_address}, 32'h3fff);
        check("wsm_data", {23'd0, mem_data}, 32'd12);
        check("wsm_no_reg_wr", {31'd0, reg_wr}, 32'd0);
        step();

        // Screen hold: three WSMs queue up, then drain 2 cycles apart
        printting_screen = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            clk_en = 1'b1; dataA = (i << 4) | 32'd1; dataB = 32'd100 + i;
            step();
            check("hold_done", {31'd0, done_instruction}, 32'd1);
            check("hold_no_wr", {31'd0, mem_wr}, 32'd0);
        end
        clk_en = 1'b0;
        step();
        check("hold_level", {28'd0, fifo_level}, 32'd3);
        check("hold_no_wr2", {31'd0, mem_wr}, 32'd0);
        printting_screen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("drain_wr", {31'd0, mem_wr}, 32'd1);
            check("drain_addr", {18'd0, mem_address}, i);
            check("drain_data", {23'd0, mem_data}, 32'd100 + i);
            step();
            check("drain_gap", {31'd0, mem_wr}, 32'd0);
        end
        check("drain_level", {28'd0, fifo_level}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);

        // Full FIFO: 8 accepted, 9th in skid, 10th is a violation
        printting_screen = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            clk_en = 1'b1; dataA = (i << 4) | 32'd1; dataB = i;
            step();
            check("full_done", {31'd0, done_instruction}, 32'd1);
        end
        dataA = (32'd9 << 4) | 32'd1; dataB = 32'd9;
        step();
        check("skid_no_done", {31'd0, done_instruction}, 32'd0);
        check("skid_level", {28'd0, fifo_level}, 32'd8);
        check("skid_no_err", {31'd0, error_sticky}, 32'd0);
        dataA = (32'd10 << 4) | 32'd1; dataB = 32'd10;
        step();
        clk_en = 1'b0;
        check("viol_err", {31'd0, error_sticky}, 32'd1);
        check("viol_no_done", {31'd0, done_instruction}, 32'd0);
        check("viol_busy", {31'd0, busy}, 32'd1);
`ifdef IDU_DROP_COUNT_EN
        check("viol_drop", {24'd0, drop_count}, 32'd1);
`endif
        printting_screen = 1'b0;
        writes = 0; dones = 0; next_addr = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (mem_wr) begin
                check("full_order", {18'd0, mem_address}, next_addr);
                next_addr++;
                writes++;
            end
            if (done_instruction) dones++;
            if (!busy) break;
        end
        check("full_writes", writes, 32'd9);
        check("full_skid_done", dones, 32'd1);
        check("full_level_end", {28'd0, fifo_level}, 32'd0);
        check("full_busy_end", {31'd0, busy}, 32'd0);

        // Reset mid-queue drops everything
        printting_screen = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            clk_en = 1'b1; dataA = (i << 4); dataB = i;
            step();
        end
        clk_en = 1'b0;
        check("rq_level", {28'd0, fifo_level}, 32'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rq_level0", {28'd0, fifo_level}, 32'd0);
        check("rq_busy0", {31'd0, busy}, 32'd0);
        check("rq_done0", {31'd0, done_instruction}, 32'd0);
        check("rq_err0", {31'd0, error_sticky}, 32'd0);
        printting_screen = 1'b0;
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (reg_wr || mem_wr || done_instruction) strobes++;
        end
        check("rq_quiet", strobes, 32'd0);

        // Illegal opcode, then a normal WBR
        clk_en = 1'b1; dataA = 32'h237; dataB = 32'h55;
        step();
        clk_en = 1'b0;
        check("ill_done", {31'd0, done_instruction}, 32'd1);
        step();
        check("ill_no_reg", {31'd0, reg_wr}, 32'd0);
        check("ill_no_mem", {31'd0, mem_wr}, 32'd0);
        check("ill_err", {31'd0, error_sticky}, 32'd1);
`ifdef IDU_DROP_COUNT_EN
        check("ill_drop", {24'd0, drop_count}, 32'd1);
`endif
        step();
        clk_en = 1'b1; dataA = 32'h90; dataB = 32'hDEADBEEF;
        step();
        clk_en = 1'b0;
        check("post_done", {31'd0, done_instruction}, 32'd1);
        step();
        check("post_reg_wr", {31'd0, reg_wr}, 32'd1);
        check("post_reg_num", {27'd0, reg_num}, 32'd9);
        check("post_reg_data", reg_data, 32'hDEADBEEF);
        check("post_err_kept", {31'd0, error_sticky}, 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_dispatch_unit.md
Name: instr_dispatch_unit

Overview:
- Buffered front-end between the Nios custom-instruction port (clk_en/dataA/dataB) and the sprite register bank and sprite memory.
- Accepts host instructions into a parametrised FIFO and acknowledges them immediately.
- Decodes each instruction into a register-bank write (WBR) or sprite-memory write (WSM) and issues it only while the print module is not scanning (printting_screen low).
- Successor to the current unbuffered decode/control path: configurable depth and field widths, backpressure skid register, illegal-opcode detection.

Parameters:
- FIFO_DEPTH, 8: instruction FIFO entries; power of 2, >=2.
- OPCODE_W, 4: opcode field width, dataA[OPCODE_W-1:0].
- ADDR_W, 14: address field width, dataA[OPCODE_W+ADDR_W-1:OPCODE_W]; OPCODE_W+ADDR_W <= 32.
- REG_W, 5: register-number width, taken from the low bits of the address field.
- MEM_DATA_W, 9: sprite pixel width, taken from dataB[MEM_DATA_W-1:0].
- OP_WBR, 0: opcode value for a register-bank write.
- OP_WSM, 1: opcode value for a sprite-memory write.

Ports:
- clk  in  1  system clock (100 MHz domain).
- reset  in  1  synchronous, active-high.
- clk_en  in  1  one-cycle host instruction strobe.
- dataA  in  32  opcode + address.
- dataB  in  32  write data.
- printting_screen  in  1  high while the print module reads registers/memory.
- done_instruction  out  1  one-cycle acceptance pulse to the host.
- reg_wr  out  1  register-bank write strobe.
- reg_num  out  REG_W  register number.
- reg_data  out  32  register data (= dataB).
- mem_wr  out  1  sprite-memory write strobe.
- mem_address  out  ADDR_W  sprite-memory address.
- mem_data  out  MEM_DATA_W  sprite pixel data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high if FIFO non-empty, skid register valid, or FSM not in IDLE.
- error_sticky  out  1  set by an illegal opcode or host protocol violation; cleared only by reset.

Behaviour:
- Reset: synchronous. FIFO flushed, skid cleared, FSM to IDLE. All outputs 0. Reset mid-operation drops queued and pending instructions with no done pulse.
- Accept:
  - clk_en=1 and FIFO not full (full judged before this edge): {dataA,dataB} pushed; done_instruction=1 on the next cycle, for 1 cycle.
  - clk_en=1 and FIFO full: instruction loaded into the skid register; done is withheld.
  - On the first cycle the FIFO is not full, skid contents are pushed and done_instruction pulses 1 cycle later.
  - clk_en while skid is valid: instruction ignored, error_sticky<=1, no done.
- Simultaneous push and pop in one cycle: both occur; fifo_level unchanged.
- Skid push has priority over a new clk_en push; a new clk_en in that cycle counts as a skid-valid violation.
- Dispatch FSM:
  - IDLE: if FIFO non-empty and printting_screen=0, pop head into the issue register, go to ISSUE. Otherwise stay.
  - ISSUE: decode the issue register.
    - opcode==OP_WBR: reg_wr=1, reg_num=addr[REG_W-1:0], reg_data=dataB.
    - opcode==OP_WSM: mem_wr=1, mem_address=addr, mem_data=dataB[MEM_DATA_W-1:0].
    - Any other opcode: no strobe, error_sticky<=1.
    - Go to IDLE.
  - Strobes are high exactly 1 cycle. Data/address outputs hold their last value between strobes.
  - Throughput: 1 instruction per 2 cycles.
  - Latency: empty FIFO, printting_screen low, clk_en at cycle 0 → push at edge 0, pop at edge 1, strobe during cycle 2.
- printting_screen is sampled only in IDLE. A rise during ISSUE does not abort the in-flight write.
- fifo_level wraps never; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: IDU_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count [7:0]: counts ignored clk_en (skid violation) and illegal opcodes.
  - Saturates at 8'hFF; reset to 0.
- Undefined:
  - Port absent; only error_sticky reports these events.

Test Plan:
- Single WBR, idle screen: dataA=32'h50, dataB=32'd694310912 → done pulse at cycle 1; reg_wr at cycle 2 with reg_num=5, reg_data=32'd694310912.
- Single WSM: dataA=32'h3fff1, dataB=32'd12 → mem_wr=1, mem_address=14'h3fff, mem_data=9'd12; reg_wr stays 0.
- Screen hold: printting_screen=1, push 3 WSMs → 3 done pulses, fifo_level=3, no mem_wr. Drop printting_screen → 3 mem_wr pulses 2 cycles apart, in order, then fifo_level=0, busy=0.
- Full/backpressure: printting_screen=1, push 9 with FIFO_DEPTH=8 → 8 done pulses, 9th held in skid. 10th clk_en → error_sticky=1. Release screen → 9th done pulse after first pop; 9 writes total.
- Illegal opcode: dataA[3:0]=4'h7 → done pulse, no strobe, error_sticky=1. Subsequent WBR still issues normally.
- Reset mid-queue: 4 queued, assert reset 1 cycle → fifo_level=0, busy=0, no strobes or done pulses afterwards.
